// File: rtl/fib_seq_pkg.sv
// Shared definitions for the Fibonacci sequence generator:
// FSM state encoding and default datapath widths.
package fib_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_n.sv
// WIDTH-bit ripple-carry adder, carry-in fixed at 0, carry-out exported
// so the caller can detect wrap-around of the sum.
module adder_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign carry_o = carry[WIDTH];

endmodule

// File: rtl/fib_seq_gen.sv
// Flow-controlled Fibonacci-style sequence generator.
// Seeds two terms on start, streams up to max_terms terms over valid/ready,
// and keeps a sticky overflow flag once a wrapped term reaches out_data.
// Optional build macro FIB_SEQ_GEN_STOP_ON_OVF_EN: end the run instead of
// emitting the first wrapped term.
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] max_terms,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_index,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

`ifdef FIB_SEQ_GEN_STOP_ON_OVF_EN
  localparam bit STOP_ON_OVF = 1'b1;
`else
  localparam bit STOP_ON_OVF = 1'b0;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             b_wrap_q;   // b_q holds a term whose true value wrapped
  logic             ovf_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] b_d;
  logic             carry_d;
  logic             hs;
  logic             last_beat;

  adder_n #(.WIDTH(WIDTH)) u_adder (
    .a_i    (a_q),
    .b_i    (b_q),
    .sum_o  (b_d),
    .carry_o(carry_d)
  );

  assign hs = valid_q & out_ready;

  // The run ends after the final counted term, or early when the next term
  // would be a wrapped one and the stop-on-overflow build is selected.
  assign last_beat = (cnt_q == CNT_W'(1)) | (STOP_ON_OVF & b_wrap_q);

  // Control FSM and datapath registers, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      b_wrap_q <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q      <= seed0;
            b_q      <= seed1;
            cnt_q    <= max_terms;
            idx_q    <= '0;
            b_wrap_q <= 1'b0;
            ovf_q    <= 1'b0;
            if (max_terms == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            a_q      <= b_q;
            b_q      <= b_d;
            idx_q    <= idx_q + CNT_W'(1);
            cnt_q    <= cnt_q - CNT_W'(1);
            b_wrap_q <= b_wrap_q | carry_d;
            // b_wrap_q describes the term moving into a_q, so overflow
            // rises together with the first wrapped term on out_data.
            ovf_q    <= ovf_q | b_wrap_q;
            if (last_beat) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = a_q;
  assign out_index = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen (WIDTH=8 so wrap-around is reachable).
// Expected beats come from a plain-arithmetic Fibonacci model; a negedge
// monitor pops and compares whenever a handshake or done pulse is seen.
module tb_fib_seq_gen;

  localparam int W   = 8;
  localparam int CW  = 8;
  localparam int CAP = 1 << 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  seed0 = '0;
  logic [W-1:0]  seed1 = '0;
  logic [CW-1:0] max_terms = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_index;
  logic          busy;
  logic          done;
  logic          overflow;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed0    (seed0),
    .seed1    (seed1),
    .max_terms(max_terms),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_index(out_index),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] idx;
    logic          ovf;
    logic          last;
  } beat_t;

  beat_t beat_q[$];
  bit    done_exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int rcyc = 0;
  bit last_final = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: term k is the k-th Fibonacci-style term of the seeds. Its true
  // value (saturated far above 2^W) decides whether it wrapped; its value
  // mod 2^W is what the stream carries.
  task automatic model_run(input int s0, input int s1, input int m);
    int tv[0:256];
    int dv[0:256];
    bit wr[0:256];
    int n;
    for (int k = 0; k <= m; k++) begin
      if (k == 0) begin
        tv[k] = s0; dv[k] = s0;
      end else if (k == 1) begin
        tv[k] = s1; dv[k] = s1;
      end else begin
        tv[k] = tv[k-1] + tv[k-2];
        if (tv[k] > CAP) tv[k] = CAP;
        dv[k] = (dv[k-1] + dv[k-2]) % (1 << W);
      end
      wr[k] = (tv[k] >= (1 << W));
    end
    n = m;
`ifdef FIB_SEQ_GEN_STOP_ON_OVF_EN
    for (int k = 0; k < m; k++) begin
      if (wr[k]) begin
        n = k;
        break;
      end
    end
`endif
    for (int k = 0; k < n; k++)
      beat_q.push_back('{data: W'(dv[k]), idx: CW'(k), ovf: wr[k], last: (k == n - 1)});
    last_final = (n == 0) ? 1'b0 : wr[n];
    done_exp_q.push_back(last_final);
  endtask

  // Downstream ready: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((rcyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  bit            stall_prev = 1'b0;
  bit            want_done = 1'b0;
  logic [W-1:0]  pdata;
  logic [CW-1:0] pidx;
  beat_t         e;
  bit            eo;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      want_done  = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {out_valid, out_data, out_index}, {1'b1, pdata, pidx});
      if (want_done) begin
        check("done_after_last", done, 1);
        want_done = 1'b0;
      end
      if (out_valid)
        check("busy_in_run", busy, 1);
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got idx=%0d data=%0d, expected none", out_index, out_data);
        end else begin
          e = beat_q.pop_front();
          check("beat", {out_data, out_index, overflow}, {e.data, e.idx, e.ovf});
          $display("beat idx=%0d data=%0d ovf=%0d", out_index, out_data, overflow);
          if (e.last) want_done = 1'b1;
        end
      end
      stall_prev = out_valid && !out_ready;
      pdata = out_data;
      pidx  = out_index;
      if (done) begin
        done_cnt++;
        if (done_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          eo = done_exp_q.pop_front();
          check("done_ovf", overflow, eo);
          $display("done ovf=%0d", overflow);
        end
      end
    end
  end

  task automatic issue(input int s0, input int s1, input int m, input bit modeled);
    @(posedge clk);
    #1;
    seed0 = W'(s0); seed1 = W'(s1); max_terms = CW'(m); start = 1'b1;
    if (modeled) model_run(s0, s1, m);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (modeled) begin
      #1;
      if (m == 0) check("zero_len_done", done, 1);
      else        check("start_latency", out_valid, 1);
    end
  endtask

  task automatic wait_done(input int tgt);
    bit hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (done_cnt >= tgt) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, tgt);
    end else begin
      #3;
      check("idle_ovf", overflow, last_final);
      check("idle_valid", {out_valid, busy}, 0);
    end
  endtask

  task automatic run(input int s0, input int s1, input int m, input int mode);
    int tgt;
    ready_mode = mode;
    tgt = done_cnt + 1;
    issue(s0, s1, m, 1'b1);
    wait_done(tgt);
  endtask

  initial begin
    int tgt;
    bit hit;
    #3;
    check("reset_outputs", {out_valid, out_data, out_index, busy, done, overflow}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(1, 1, 10, 0);      // basic sequence
    run(2, 1, 5, 1);       // backpressure
    run(1, 1, 20, 0);      // wrap-around at index 13
    run(7, 9, 0, 0);       // zero length

    // Start during RUN must be ignored.
    ready_mode = 2;
    tgt = done_cnt + 1;
    issue(5, 8, 15, 1'b1);
    repeat (4) @(posedge clk);
    issue(100, 200, 3, 1'b0);
    wait_done(tgt);

    // Asynchronous reset in the middle of a run.
    ready_mode = 0;
    issue(1, 1, 20, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (out_valid && out_index == CW'(4)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_cmp++; n_err++;
      $display("FAIL reach_index4: got idx=%0d, expected 4", out_index);
    end
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", {out_valid, out_data, out_index, busy, done, overflow}, 0);
    beat_q.delete();
    done_exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(3, 4, 3, 0);

    run(200, 100, 255, 0); // longest run, wraps early

    for (int r = 0; r < 30; r++)
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 40)), int'($urandom_range(0, 2)));

    check("scoreboard_drained", beat_q.size() + done_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
